// File: rtl/emu_doppler_wipeoff.sv
// -----------------------------------------------------------------------------
// emu_doppler_wipeoff
//
// Removes a commanded Doppler rotation from a stream of 6-bit complex samples.
// Each accepted sample is multiplied by the conjugate of an internal NCO phasor.
// The derotated terms are then integrated over ACC_LEN samples (integrate and
// dump).
//
// Parameters:
//   ACC_LEN  samples per integrate-and-dump period (>= 2)
//   ACC_W    signed accumulator/output width (>= 13 + clog2(ACC_LEN))
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   dv_in      one-cycle strobe: real_in/imag_in/freq valid
//   freq       unsigned phase increment per sample (full circle = 2^32)
//   real_in    signed sample, real part
//   imag_in    signed sample, imaginary part
//   dv_out     one-cycle strobe: i_out/q_out updated
//   i_out      signed integrated in-phase result (held between dumps)
//   q_out      signed integrated quadrature result (held between dumps)
//   phase_out  (only with EMU_WIPEOFF_PHASE_OUT_EN) phase accumulator value
//              after the last sample of the dumped period
//
// Optional feature macro: EMU_WIPEOFF_PHASE_OUT_EN
//
// Pipeline: S1 registers the sample and the LUT phasor, S2 registers the four
// products, and S3 accumulates and dumps. dv_out rises 3 cycles after the
// strobe that carries the last sample of a period.
// -----------------------------------------------------------------------------
module emu_doppler_wipeoff #(
  parameter int ACC_LEN = 16,
  parameter int ACC_W   = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dv_in,
  input  logic [31:0]             freq,
  input  logic signed [5:0]       real_in,
  input  logic signed [5:0]       imag_in,
  output logic                    dv_out,
  output logic signed [ACC_W-1:0] i_out,
  output logic signed [ACC_W-1:0] q_out
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
  ,
  output logic [31:0]             phase_out
`endif
);

  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  // First quadrant of round(31*cos(2*pi*m/64)), m = 0..16.
  function automatic logic [4:0] quarter_mag(input logic [4:0] m);
    logic [4:0] v;
    case (m)
      5'd0, 5'd1: v = 5'd31;
      5'd2, 5'd3: v = 5'd30;
      5'd4:       v = 5'd29;
      5'd5:       v = 5'd27;
      5'd6:       v = 5'd26;
      5'd7:       v = 5'd24;
      5'd8:       v = 5'd22;
      5'd9:       v = 5'd20;
      5'd10:      v = 5'd17;
      5'd11:      v = 5'd15;
      5'd12:      v = 5'd12;
      5'd13:      v = 5'd9;
      5'd14:      v = 5'd6;
      5'd15:      v = 5'd3;
      default:    v = 5'd0;
    endcase
    return v;
  endfunction

  // Full-circle cosine folded onto the quarter table.
  function automatic logic signed [5:0] cos_lut(input logic [5:0] k);
    logic [5:0]        m;
    logic              neg;
    logic signed [5:0] mag;
    if (k <= 6'd16) begin
      m = k;             neg = 1'b0;
    end else if (k <= 6'd32) begin
      m = 6'd32 - k;     neg = 1'b1;
    end else if (k <= 6'd48) begin
      m = k - 6'd32;     neg = 1'b1;
    end else begin
      m = 6'd0 - k;      neg = 1'b0;   // 64 - k, modulo 64
    end
    mag = $signed({1'b0, quarter_mag(m[4:0])});
    return neg ? -mag : mag;
  endfunction

  // sin(theta) = cos(theta - quarter turn)
  function automatic logic signed [5:0] sin_lut(input logic [5:0] k);
    return cos_lut(k - 6'd16);
  endfunction

  // Phase accumulator
  logic [31:0]             phase_q, phase_d;
  // S1: sample and phasor
  logic                    s1_v_q, s1_v_d;
  logic signed [5:0]       s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic signed [5:0]       s1_c_q, s1_c_d, s1_s_q, s1_s_d;
  // S2: products
  logic                    s2_v_q, s2_v_d;
  logic signed [11:0]      s2_rc_q, s2_rc_d, s2_is_q, s2_is_d;
  logic signed [11:0]      s2_ic_q, s2_ic_d, s2_rs_q, s2_rs_d;
  // S3: integrate and dump
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                    dv_out_q, dv_out_d;
  logic signed [ACC_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  // Combinational S3 terms
  logic signed [12:0]      term_i, term_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
  // The post-sample phase travels with its sample so the dump reports P(n+1)
  // even when later samples have already advanced the accumulator.
  logic [31:0]             s1_ph_q, s1_ph_d, s2_ph_q, s2_ph_d;
  logic [31:0]             phase_out_q, phase_out_d;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned;
    // otherwise a latch would be inferred.
    phase_d  = phase_q;
    s1_v_d   = dv_in;
    s1_re_d  = s1_re_q;
    s1_im_d  = s1_im_q;
    s1_c_d   = s1_c_q;
    s1_s_d   = s1_s_q;
    s2_v_d   = s1_v_q;
    s2_rc_d  = s2_rc_q;
    s2_is_d  = s2_is_q;
    s2_ic_d  = s2_ic_q;
    s2_rs_d  = s2_rs_q;
    cnt_d    = cnt_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    dv_out_d = 1'b0;
    i_out_d  = i_out_q;
    q_out_d  = q_out_q;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
    s1_ph_d     = s1_ph_q;
    s2_ph_d     = s2_ph_q;
    phase_out_d = phase_out_q;
`endif

    // S1: the sample uses the phase before this sample's increment.
    if (dv_in) begin
      s1_re_d = real_in;
      s1_im_d = imag_in;
      s1_c_d  = cos_lut(phase_q[31:26]);
      s1_s_d  = sin_lut(phase_q[31:26]);
      phase_d = phase_q + freq;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
      s1_ph_d = phase_q + freq;
`endif
    end

    // S2: (r + j*i)(c - j*s), full-precision products
    if (s1_v_q) begin
      s2_rc_d = 12'(s1_re_q) * 12'(s1_c_q);
      s2_is_d = 12'(s1_im_q) * 12'(s1_s_q);
      s2_ic_d = 12'(s1_im_q) * 12'(s1_c_q);
      s2_rs_d = 12'(s1_re_q) * 12'(s1_s_q);
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
      s2_ph_d = s1_ph_q;
`endif
    end

    // S3
    term_i = 13'(s2_rc_q) + 13'(s2_is_q);
    term_q = 13'(s2_ic_q) - 13'(s2_rs_q);
    sum_i  = acc_i_q + ACC_W'(term_i);
    sum_q  = acc_q_q + ACC_W'(term_q);
    if (s2_v_q) begin
      if (cnt_q == CNT_LAST) begin
        i_out_d  = sum_i;
        q_out_d  = sum_q;
        dv_out_d = 1'b1;
        acc_i_d  = '0;
        acc_q_d  = '0;
        cnt_d    = '0;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
        phase_out_d = s2_ph_q;
`endif
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: pipeline data is cleared along with the valids; these are
      // plain flops and not a RAM, so the reset costs nothing structural.
      phase_q  <= '0;
      s1_v_q   <= 1'b0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
      s1_c_q   <= '0;
      s1_s_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_rc_q  <= '0;
      s2_is_q  <= '0;
      s2_ic_q  <= '0;
      s2_rs_q  <= '0;
      cnt_q    <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      dv_out_q <= 1'b0;
      i_out_q  <= '0;
      q_out_q  <= '0;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
      s1_ph_q     <= '0;
      s2_ph_q     <= '0;
      phase_out_q <= '0;
`endif
    end else begin
      phase_q  <= phase_d;
      s1_v_q   <= s1_v_d;
      s1_re_q  <= s1_re_d;
      s1_im_q  <= s1_im_d;
      s1_c_q   <= s1_c_d;
      s1_s_q   <= s1_s_d;
      s2_v_q   <= s2_v_d;
      s2_rc_q  <= s2_rc_d;
      s2_is_q  <= s2_is_d;
      s2_ic_q  <= s2_ic_d;
      s2_rs_q  <= s2_rs_d;
      cnt_q    <= cnt_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      dv_out_q <= dv_out_d;
      i_out_q  <= i_out_d;
      q_out_q  <= q_out_d;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
      s1_ph_q     <= s1_ph_d;
      s2_ph_q     <= s2_ph_d;
      phase_out_q <= phase_out_d;
`endif
    end
  end

  assign dv_out = dv_out_q;
  assign i_out  = i_out_q;
  assign q_out  = q_out_q;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
  assign phase_out = phase_out_q;
`endif

endmodule

// File: tb/tb_emu_doppler_wipeoff.sv
// -----------------------------------------------------------------------------
// tb_emu_doppler_wipeoff
//
// Self-checking bench for emu_doppler_wipeoff. Stimulus runs through a
// reference model whose phasor table comes from $cos/$sin with round-half-
// away-from-zero. Each completed period pushes its expected dump, including
// the cycle it must appear in, onto a scoreboard. A monitor pops and compares
// the scoreboard entry on every dv_out. The directed cases also check the
// literal results for known input patterns.
// -----------------------------------------------------------------------------
module tb_emu_doppler_wipeoff;

  localparam int ACC_LEN = 16;
  localparam int ACC_W   = 20;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    dv_in;
  logic [31:0]             freq;
  logic signed [5:0]       real_in;
  logic signed [5:0]       imag_in;
  logic                    dv_out;
  logic signed [ACC_W-1:0] i_out;
  logic signed [ACC_W-1:0] q_out;
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
  logic [31:0]             phase_out;
`endif

  emu_doppler_wipeoff #(.ACC_LEN(ACC_LEN), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .dv_in    (dv_in),
    .freq     (freq),
    .real_in  (real_in),
    .imag_in  (imag_in),
    .dv_out   (dv_out),
    .i_out    (i_out),
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
    .q_out    (q_out),
    .phase_out(phase_out)
`else
    .q_out    (q_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int dumps_seen = 0;

  typedef struct {
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
    logic [31:0]             ph;
    int                      cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int          m_i, m_q, m_cnt;
  logic [31:0] m_ph;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int round_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int lut_cos(input int k);
    return round_away(31.0 * $cos(2.0 * 3.14159265358979 * k / 64.0));
  endfunction

  function automatic int lut_sin(input int k);
    return round_away(31.0 * $sin(2.0 * 3.14159265358979 * k / 64.0));
  endfunction

  task automatic model_reset();
    m_i = 0; m_q = 0; m_cnt = 0; m_ph = '0;
  endtask

  // Called at posedge+1 with the cycle in which dv_in is driven high.
  task automatic model_sample(input logic signed [5:0] r, input logic signed [5:0] im,
                              input logic [31:0] f);
    int   k, c, s;
    exp_t e;
    k = int'(m_ph[31:26]);
    c = lut_cos(k);
    s = lut_sin(k);
    m_i += int'(r) * c + int'(im) * s;
    m_q += int'(im) * c - int'(r) * s;
    m_ph += f;
    m_cnt++;
    if (m_cnt == ACC_LEN) begin
      e.i   = ACC_W'(m_i);
      e.q   = ACC_W'(m_q);
      e.ph  = m_ph;
      e.cyc = cyc + 3;
      sb.push_back(e);
      m_i = 0; m_q = 0; m_cnt = 0;
    end
  endtask

  // Drive one strobe, then 'idle' cycles of garbage with dv_in low.
  task automatic send(input logic signed [5:0] r, input logic signed [5:0] im,
                      input logic [31:0] f, input int idle);
    dv_in = 1'b1; real_in = r; imag_in = im; freq = f;
    model_sample(r, im, f);
    @(posedge clk); #1;
    dv_in = 1'b0;
    real_in = 6'($urandom_range(0, 63));
    imag_in = 6'($urandom_range(0, 63));
    freq    = $urandom;
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dv_in = 1'b1;                        // must be ignored while in reset
    real_in = 6'sd7; imag_in = -6'sd9; freq = 32'h1357_9BDF;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    dv_in = 1'b0;
    model_reset();
  endtask

  task automatic wait_dumps(input int target);
    int budget = 400;
    while (dumps_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("dump_wait", dumps_seen, target);
  endtask

  // Monitor: every dv_out must match the oldest scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dv_out === 1'b1) begin
        check("dv_out_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("dump_i", i_out, e.i);
          check("dump_q", q_out, e.q);
          check("dump_cycle", cyc, e.cyc);
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
          check("dump_phase", 64'(phase_out), 64'(e.ph));
`endif
        end
        dumps_seen++;
      end
    end
  end

  initial begin
    model_reset();
    reset = 1'b1;
    dv_in = 1'b1;
    freq = 32'hDEAD_BEEF; real_in = 6'sd5; imag_in = 6'sd3;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    dv_in = 1'b0;
    @(negedge clk);
    check("rst_dv_out", dv_out, 0);
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
    check("rst_phase_out", 64'(phase_out), 0);
`endif
    @(posedge clk); #1;

    // 1: DC real input, spaced strobes
    for (int n = 0; n < ACC_LEN; n++) send(6'sd10, 6'sd0, 32'h0, 15);
    wait_dumps(1);
    check("t1_i", i_out, 4960);
    check("t1_q", q_out, 0);
    @(posedge clk); #1;

    // 2: DC imaginary input
    for (int n = 0; n < ACC_LEN; n++) send(6'sd0, -6'sd5, 32'h0, 15);
    wait_dumps(2);
    check("t2_i", i_out, 0);
    check("t2_q", q_out, -2480);
    @(posedge clk); #1;

    // 3: half-rate rotation cancels a constant input
    for (int n = 0; n < ACC_LEN; n++) send(6'sd10, 6'sd0, 32'h8000_0000, 15);
    wait_dumps(3);
    check("t3_i", i_out, 0);
    check("t3_q", q_out, 0);
    @(posedge clk); #1;

    // 4: back-to-back strobes
    for (int n = 0; n < ACC_LEN; n++) send(6'sd10, 6'sd0, 32'h0, 0);
    wait_dumps(4);
    check("t4_i", i_out, 4960);
    check("t4_q", q_out, 0);
    @(posedge clk); #1;

    // 5: reset one cycle after the 7th strobe discards the partial period
    for (int n = 0; n < 6; n++) send(6'sd10, 6'sd0, 32'h0, 2);
    send(6'sd10, 6'sd0, 32'h0, 0);
    do_reset();
    @(negedge clk);
    check("t5_rst_i", i_out, 0);
    check("t5_rst_dv", dv_out, 0);
    @(posedge clk); #1;
    for (int n = 0; n < ACC_LEN; n++) send(6'sd10, 6'sd0, 32'h0, 1);
    wait_dumps(5);
    check("t5_i", i_out, 4960);
    check("t5_q", q_out, 0);
    @(posedge clk); #1;

    // 6: fixed increment from phase 0, random samples, two periods
    do_reset();
    for (int n = 0; n < ACC_LEN; n++)
      send(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 32'h0123_4567,
           int'($urandom_range(0, 2)));
    wait_dumps(6);
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
    check("t6_phase1", 64'(phase_out), 64'(32'h1234_5670));
`endif
    @(posedge clk); #1;
    for (int n = 0; n < ACC_LEN; n++)
      send(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 32'h0123_4567,
           int'($urandom_range(0, 2)));
    wait_dumps(7);
`ifdef EMU_WIPEOFF_PHASE_OUT_EN
    check("t6_phase2", 64'(phase_out), 64'(32'h2468_ACE0));
`endif
    @(posedge clk); #1;

    // 7: random samples, random increments that change mid-period, mixed spacing
    for (int p = 0; p < 3; p++) begin
      logic [31:0] f;
      f = $urandom;
      for (int n = 0; n < ACC_LEN; n++) begin
        if (n == ACC_LEN / 2) f = $urandom;
        send(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), f,
             int'($urandom_range(0, 2)));
      end
    end
    wait_dumps(10);

    repeat (8) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
